frost32_instr_fetch: RTL and testbench
======================================

# frost32_instr_fetch

Instruction fetch stage for the Frost32 pipeline, sitting directly upstream of the instruction decode stage. Issues 32-bit instruction reads to the memory interface, buffers returned words with their PCs in a small prefetch FIFO, and presents them to decode with a valid/ready handshake. Decode or execute redirects the fetch PC for taken branches and other control flow. Redirects flush the buffer and squash any in-flight read.

## Interface
- `ADDR_WIDTH`, 32: width of all addresses and PCs.
- `FIFO_DEPTH`, 4: prefetch entries; must be a power of two and at least 2.
- `RESET_PC`, 0: first fetch address; must be 4-byte aligned.

Ports:
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mem_req`  out  1: read request, always 32-bit size.
- `mem_addr`  out  ADDR_WIDTH: read address; bits [1:0] always 0.
- `mem_wait`  in  1: memory busy. A request is accepted in any cycle with `mem_req && !mem_wait`.
- `mem_rvalid`  in  1: read data valid. Responses are in order, at most one outstanding, and arrive no earlier than the cycle after acceptance.
- `mem_rdata`  in  32: read data, qualified by `mem_rvalid`.
- `redirect_valid`  in  1: single-cycle pulse that redirects fetch.
- `redirect_pc`  in  ADDR_WIDTH: new fetch PC; bits [1:0] are ignored and treated as 0.
- `instr_valid`  out  1: FIFO head valid; high exactly when the FIFO is not empty.
- `instr_data`  out  32: FIFO head instruction.
- `instr_pc`  out  ADDR_WIDTH: FIFO head PC.
- `instr_ready`  in  1: decode consumes the head when `instr_valid && instr_ready`.

## Operation
Registers:
- `fetch_pc`: next address to request.
- `req_pc`: PC of the outstanding read.
- FIFO storage, read/write pointers and `count` (0..FIFO_DEPTH).
- State register.

States and transitions:
- ST_ISSUE: no read outstanding.
  - `mem_req = !redirect_valid && (count < FIFO_DEPTH)`, combinational.
  - `mem_addr = fetch_pc`.
  - On acceptance: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (wraps modulo 2^ADDR_WIDTH), go to ST_WAIT.
- ST_WAIT: one read outstanding; `mem_req = 0`.
  - On `mem_rvalid`: push `{mem_rdata, req_pc}`, go to ST_ISSUE.
  - FIFO space for this response is guaranteed because a request is only issued when `count < FIFO_DEPTH`.
- ST_SQUASH: outstanding read belongs to a flushed path; `mem_req = 0`.
  - On `mem_rvalid`: discard the data, go to ST_ISSUE.

Redirect, when `redirect_valid` = 1 (highest priority):
- `fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}`.
- FIFO flushed: pointers and `count` cleared to 0.
- A pop in the same cycle has no additional effect.
- From ST_WAIT, go to ST_SQUASH. If `mem_rvalid` is also high that cycle, the response is dropped and the state goes to ST_ISSUE instead.
- From ST_SQUASH, stay in ST_SQUASH. If `mem_rvalid` is also high that cycle, go to ST_ISSUE.
- From ST_ISSUE, stay in ST_ISSUE; `mem_req` is held low that cycle.

FIFO:
- Push and pop in the same cycle leave `count` unchanged.
- Pop when empty is impossible because `instr_valid` = 0.
- `mem_rvalid` in ST_ISSUE is a protocol error and is ignored.

Reset (`rst_n` = 0, at any time including mid-read):
- State ST_ISSUE, `fetch_pc = RESET_PC`, `count = 0`, FIFO storage cleared.
- Outputs: `mem_req` = 0, `mem_addr` = RESET_PC, `instr_valid` = 0, `instr_data` = 0, `instr_pc` = 0.
- Memory must drop any pending response across reset. A stray `mem_rvalid` after reset is ignored per the ST_ISSUE rule.

## Timing
- Cycle after `rst_n` rises: `mem_req` = 1, `mem_addr` = RESET_PC.
- Fetch-to-decode latency: `instr_valid` rises the cycle after the `mem_rvalid` that carries the word (registered FIFO write).
- Throughput: one request per response round trip. The next `mem_req` is asserted the cycle after `mem_rvalid`.
- Redirect with no read outstanding: `mem_req` with the redirected address in the cycle after `redirect_valid`.
- Redirect with a read outstanding: `mem_req` with the redirected address in the cycle after the squashed `mem_rvalid`.
- `instr_valid` falls the cycle after a redirect.
- FIFO full (`count == FIFO_DEPTH`): `mem_req` stays low until a pop is registered; it is asserted the cycle after that pop.

## Test plan
- Reset/fetch, zero-wait memory with 1-cycle response latency, `instr_ready` = 1: requests issued at 0x0, 0x4, 0x8, … one per 2 cycles; decode receives matching `instr_pc` and data in order.
- Backpressure, `FIFO_DEPTH` = 4, `instr_ready` = 0: exactly 4 reads accepted (0x0–0xC), then `mem_req` stays low. Raise `instr_ready` for one cycle: a pop of 0x0 occurs and the next cycle requests 0x10.
- `mem_wait` held high 5 cycles on the request to 0x8: `mem_addr` holds 0x8 with `mem_req` high throughout; no duplicate entry in the FIFO.
- Redirect to 0x103 while the read of 0x8 is outstanding: response for 0x8 is discarded, FIFO empties, and the next request is to 0x100. The first delivered `instr_pc` is 0x100.
- Redirect coincident with `mem_rvalid` and a pop: FIFO empties, the returned word is dropped, and `mem_req` for the new PC is asserted the next cycle.
- Assert `rst_n` low while in ST_WAIT with 3 entries buffered: all outputs take reset values immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/frost32_instr_fetch.sv
// Frost32 instruction fetch stage.
// Issues one 32-bit read at a time, buffers returned words together with
// their PCs in a small prefetch FIFO and hands them to decode through a
// valid/ready handshake. A redirect flushes the FIFO and squashes any read
// that is still in flight, so decode only ever sees words from the new path.
module frost32_instr_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_wait,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,

    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,

    output logic                  instr_valid,
    output logic [31:0]           instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;

    logic [31:0]           fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  fifo_full;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Head of the FIFO drives decode directly; storage is cleared on reset
    // so the head reads as zero while the stage is held in reset.
    assign instr_valid = (count != '0);
    assign instr_data  = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));

    // A request is only raised when the FIFO still has room for its answer,
    // so a response can always be pushed. rst_n gates the request so the
    // memory sees no request while reset is held.
    assign mem_req  = rst_n && (state == ST_ISSUE) && !redirect_valid && !fifo_full;
    assign mem_addr = fetch_pc;

    assign accept = mem_req && !mem_wait;

    // A redirect in the same cycle drops the returning word and any pop.
    assign push = (state == ST_WAIT) && mem_rvalid && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    // Fetch control: next PC, PC of the outstanding read and the read state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ISSUE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
            end else if (accept) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end

            if (accept) begin
                req_pc <= fetch_pc;
            end

            case (state)
                ST_ISSUE: begin
                    if (accept) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state <= ST_ISSUE;
                    end else if (redirect_valid) begin
                        state <= ST_SQUASH;
                    end
                end
                ST_SQUASH: begin
                    if (mem_rvalid) begin
                        state <= ST_ISSUE;
                    end
                end
                default: begin
                    state <= ST_ISSUE;
                end
            endcase
        end
    end

    // Prefetch FIFO: pointers wrap naturally because the depth is a power of
    // two; a redirect empties it by clearing pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_pc[wr_ptr]   <= req_pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_frost32_instr_fetch.sv
// Directed bench for the Frost32 fetch stage. The bench plays the memory
// by hand, cycle by cycle, and checks every output against hand-derived
// values. Memory words are {16'hC0DE, addr[15:0]} so data identifies its PC.
module tb_frost32_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_wait;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int vectorCount = 0;
    int missCount   = 0;

    frost32_instr_fetch #(
        .ADDR_WIDTH(32),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wait      (mem_wait),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives all DUT inputs for the current cycle, then lets them settle.
    task automatic applyStimulus(input logic wt, input logic rv, input logic [31:0] rd,
                                 input logic rdir, input logic [31:0] rpc, input logic rdy);
        mem_wait       = wt;
        mem_rvalid     = rv;
        mem_rdata      = rd;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"},   {31'd0, mem_req},     32'h0);
        checkOutput({tag, "_addr"},  mem_addr,             32'h0);
        checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'h0);
        checkOutput({tag, "_data"},  instr_data,           32'h0);
        checkOutput({tag, "_pc"},    instr_pc,             32'h0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // One full round trip: request accepted at addr, answered next cycle.
    task automatic fetchWord(input logic [31:0] addr, input logic rdy);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
        checkOutput("fw_req", {31'd0, mem_req}, 32'h1);
        checkOutput("fw_addr", mem_addr, addr);
        tick();
        applyStimulus(1'b0, 1'b1, memWord(addr), 1'b0, 32'h0, rdy);
        checkOutput("fw_wait_req", {31'd0, mem_req}, 32'h0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Reset values while held in reset.
        tick();
        checkResetOutputs("rst");
        doReset();
        checkOutput("rst_rel_req", {31'd0, mem_req}, 32'h1);
        checkOutput("rst_rel_addr", mem_addr, 32'h0);

        // Streaming fetch with decode always ready: one word per 2 cycles.
        $display("[TB] streaming fetch");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checkOutput("st_req", {31'd0, mem_req}, 32'h1);
            checkOutput("st_addr", mem_addr, 32'(4 * i));
            if (i > 0) begin
                checkOutput("st_valid", {31'd0, instr_valid}, 32'h1);
                checkOutput("st_pc", instr_pc, 32'(4 * (i - 1)));
                checkOutput("st_data", instr_data, memWord(32'(4 * (i - 1))));
            end
            tick();
            applyStimulus(1'b0, 1'b1, memWord(32'(4 * i)), 1'b0, 32'h0, 1'b1);
            checkOutput("st_wait_req", {31'd0, mem_req}, 32'h0);
            checkOutput("st_wait_valid", {31'd0, instr_valid}, 32'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("st_last_pc", instr_pc, 32'hC);
        tick();

        // Backpressure: FIFO fills with 0x0..0xC then requests stop.
        $display("[TB] backpressure");
        doReset();
        for (int i = 0; i < 4; i++) fetchWord(32'(4 * i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            checkOutput("bp_full_req", {31'd0, mem_req}, 32'h0);
            checkOutput("bp_head_pc", instr_pc, 32'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_pop_pc", instr_pc, 32'h0);
        checkOutput("bp_pop_req", {31'd0, mem_req}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("bp_resume_req", {31'd0, mem_req}, 32'h1);
        checkOutput("bp_resume_addr", mem_addr, 32'h10);
        checkOutput("bp_new_head", instr_pc, 32'h4);
        tick();

        // Memory stall on the request to 0x8.
        $display("[TB] memory wait");
        doReset();
        fetchWord(32'h0, 1'b0);
        fetchWord(32'h4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            checkOutput("mw_req", {31'd0, mem_req}, 32'h1);
            checkOutput("mw_addr", mem_addr, 32'h8);
            tick();
        end
        fetchWord(32'h8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checkOutput("mw_valid", {31'd0, instr_valid}, 32'h1);
            checkOutput("mw_pc", instr_pc, 32'(4 * i));
            checkOutput("mw_data", instr_data, memWord(32'(4 * i)));
            tick();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("mw_empty", {31'd0, instr_valid}, 32'h0);
        checkOutput("mw_next_addr", mem_addr, 32'hC);
        tick();

        // Redirect to 0x103 while the read of 0x8 is outstanding.
        $display("[TB] redirect with read outstanding");
        doReset();
        fetchWord(32'h0, 1'b0);
        fetchWord(32'h4, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_issue_addr", mem_addr, 32'h8);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0);
        checkOutput("rd_pulse_req", {31'd0, mem_req}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_flush_valid", {31'd0, instr_valid}, 32'h0);
        checkOutput("rd_squash_req", {31'd0, mem_req}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, memWord(32'h8), 1'b0, 32'h0, 1'b0);
        checkOutput("rd_squash_req2", {31'd0, mem_req}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_drop_valid", {31'd0, instr_valid}, 32'h0);
        fetchWord(32'h100, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_first_valid", {31'd0, instr_valid}, 32'h1);
        checkOutput("rd_first_pc", instr_pc, 32'h100);
        checkOutput("rd_first_data", instr_data, memWord(32'h100));
        tick();
        // Redirect from ST_ISSUE: request held low, new address next cycle.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        checkOutput("ri_pulse_req", {31'd0, mem_req}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("ri_req", {31'd0, mem_req}, 32'h1);
        checkOutput("ri_addr", mem_addr, 32'h200);
        checkOutput("ri_valid", {31'd0, instr_valid}, 32'h0);
        tick();

        // Redirect coincident with the response and a pop.
        $display("[TB] redirect with response and pop");
        doReset();
        fetchWord(32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rc_issue_addr", mem_addr, 32'h4);
        tick();
        applyStimulus(1'b0, 1'b1, memWord(32'h4), 1'b1, 32'h40, 1'b1);
        checkOutput("rc_head_pc", instr_pc, 32'h0);
        checkOutput("rc_pulse_req", {31'd0, mem_req}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rc_valid", {31'd0, instr_valid}, 32'h0);
        checkOutput("rc_req", {31'd0, mem_req}, 32'h1);
        checkOutput("rc_addr", mem_addr, 32'h40);
        tick();

        // Reset while a read is outstanding with 3 words buffered.
        $display("[TB] reset mid-read");
        doReset();
        fetchWord(32'h0, 1'b0);
        fetchWord(32'h4, 1'b0);
        fetchWord(32'h8, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("mr_issue_addr", mem_addr, 32'hC);
        tick();
        checkOutput("mr_pre_valid", {31'd0, instr_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mr_rst");
        tick();
        rst_n = 1'b1;
        #1;
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        checkOutput("mr_restart_req", {31'd0, mem_req}, 32'h1);
        checkOutput("mr_restart_addr", mem_addr, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, memWord(32'h0), 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("mr_first_pc", instr_pc, 32'h0);
        checkOutput("mr_first_data", instr_data, memWord(32'h0));
        checkOutput("mr_next_addr", mem_addr, 32'h4);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
